// File: rtl/d_debounce_edge.sv
// rtl/d_debounce_edge.sv - debounce filter with rise/fall pulses and rising-edge event counter
//
// Purpose:
//   Filters the registered q of the upstream D flip-flop stage into a
//   glitch-free level. A new level is accepted only after STABLE_CYCLES
//   consecutive equal samples. Each acceptance produces a one-cycle rise or
//   fall pulse, and accepted rising edges are counted modulo 2**EVT_W.
//
// Optional feature (macro SYNC_STAGE_EN):
//   When defined, i_d_in is passed through a 2-flop synchronizer (reset to 0)
//   before the FSM, adding 2 cycles to every latency. When undefined, i_d_in
//   feeds the FSM directly and must already be synchronous to i_clk.
//
// Ports:
//   i_clk        in   1      rising-edge clock
//   i_reset      in   1      asynchronous reset, active-high
//   i_d_in       in   1      raw input from the D flip-flop q
//   i_cnt_clr    in   1      synchronous clear of o_evt_count
//   o_level      out  1      debounced level (registered)
//   o_rise       out  1      one-cycle pulse when level goes 0->1 (registered)
//   o_fall       out  1      one-cycle pulse when level goes 1->0 (registered)
//   o_evt_count  out  EVT_W  accepted rising edges, modulo 2**EVT_W (registered)
//
// Parameters:
//   STABLE_CYCLES  consecutive equal samples to accept a new level (>= 2)
//   CNT_W          stability counter width, 2**CNT_W > STABLE_CYCLES
//   EVT_W          event counter width

module d_debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3,
  parameter int EVT_W         = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_d_in,
  input  logic             i_cnt_clr,
  output logic             o_level,
  output logic             o_rise,
  output logic             o_fall,
  output logic [EVT_W-1:0] o_evt_count
);

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'b00,
    CHECK_HIGH  = 2'b01,
    HIGH_STABLE = 2'b10,
    CHECK_LOW   = 2'b11
  } state_t;

  // Counter value seen on the edge that completes the stability window.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Input sampling
  // ---------------------------------------------------------------------------
  logic w_s;

`ifdef SYNC_STAGE_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_d_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = i_d_in;
`endif

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [CNT_W-1:0]   r_stab_cnt;
  logic               r_level;
  logic               r_rise;
  logic               r_fall;
  logic [EVT_W-1:0]   r_evt_count;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_stab_cnt_nxt;
  logic               w_level_nxt;
  logic               w_rise_nxt;
  logic               w_fall_nxt;
  logic [EVT_W-1:0]   w_evt_count_nxt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= LOW_STABLE;
      r_stab_cnt  <= '0;
      r_level     <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_evt_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_stab_cnt  <= w_stab_cnt_nxt;
      r_level     <= w_level_nxt;
      r_rise      <= w_rise_nxt;
      r_fall      <= w_fall_nxt;
      r_evt_count <= w_evt_count_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_stab_cnt_nxt = r_stab_cnt;
    w_level_nxt    = r_level;
    w_rise_nxt     = 1'b0;
    w_fall_nxt     = 1'b0;

    case (r_state)
      LOW_STABLE: begin
        w_level_nxt = 1'b0;
        if (w_s) begin
          // The edge that first sees the new value is sample 1 of the window.
          w_state_nxt    = CHECK_HIGH;
          w_stab_cnt_nxt = LP_CNT_ONE;
        end
      end

      CHECK_HIGH: begin
        if (!w_s) begin
          // Glitch rejected: back to the old level without any pulse.
          w_state_nxt    = LOW_STABLE;
          w_stab_cnt_nxt = '0;
        end else if (r_stab_cnt == LP_CNT_LAST) begin
          w_state_nxt    = HIGH_STABLE;
          w_stab_cnt_nxt = '0;
          w_level_nxt    = 1'b1;
          w_rise_nxt     = 1'b1;
        end else begin
          w_stab_cnt_nxt = r_stab_cnt + LP_CNT_ONE;
        end
      end

      HIGH_STABLE: begin
        w_level_nxt = 1'b1;
        if (!w_s) begin
          w_state_nxt    = CHECK_LOW;
          w_stab_cnt_nxt = LP_CNT_ONE;
        end
      end

      CHECK_LOW: begin
        if (w_s) begin
          w_state_nxt    = HIGH_STABLE;
          w_stab_cnt_nxt = '0;
        end else if (r_stab_cnt == LP_CNT_LAST) begin
          w_state_nxt    = LOW_STABLE;
          w_stab_cnt_nxt = '0;
          w_level_nxt    = 1'b0;
          w_fall_nxt     = 1'b1;
        end else begin
          w_stab_cnt_nxt = r_stab_cnt + LP_CNT_ONE;
        end
      end

      default: begin
        // Any corrupted encoding restarts from a known low level.
        w_state_nxt    = LOW_STABLE;
        w_stab_cnt_nxt = '0;
        w_level_nxt    = 1'b0;
      end
    endcase
  end

  // Clear takes effect before the count, so clear + accepted rise yields 1.
  always_comb begin
    w_evt_count_nxt = (i_cnt_clr ? '0 : r_evt_count) + EVT_W'(w_rise_nxt);
  end

  assign o_level     = r_level;
  assign o_rise      = r_rise;
  assign o_fall      = r_fall;
  assign o_evt_count = r_evt_count;

endmodule

// File: tb/tb_d_debounce_edge.sv
// tb/tb_d_debounce_edge.sv - directed self-checking bench for d_debounce_edge

module tb_d_debounce_edge;

`ifdef SYNC_STAGE_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clk;
  logic       reset;
  logic       d_in;
  logic       cnt_clr;
  logic       level;
  logic       rise;
  logic       fall;
  logic [7:0] evt_count;

  int checks;
  int errors;

  d_debounce_edge #(
    .STABLE_CYCLES(4),
    .CNT_W(3),
    .EVT_W(8)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_d_in(d_in),
    .i_cnt_clr(cnt_clr),
    .o_level(level),
    .o_rise(rise),
    .o_fall(fall),
    .o_evt_count(evt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic lv, input logic rs, input logic fl,
                           input logic [7:0] ev);
    check({tag, ".level"}, {31'd0, level}, {31'd0, lv});
    check({tag, ".rise"},  {31'd0, rise},  {31'd0, rs});
    check({tag, ".fall"},  {31'd0, fall},  {31'd0, fl});
    check({tag, ".evt"},   {24'd0, evt_count}, {24'd0, ev});
  endtask

  // One full accepted high then accepted low, with generous margins.
  task automatic pulse_cycle();
    d_in = 1'b1;
    repeat (6 + SL) tick();
    d_in = 1'b0;
    repeat (6 + SL) tick();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    d_in    = 1'b0;
    cnt_clr = 1'b0;

    // 1: reset state and idle low input
    repeat (2) tick();
    check_out("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out("idle_low", 1'b0, 1'b0, 1'b0, 8'd0);
    end

    // 2: three-sample high is rejected
    d_in = 1'b1;
    repeat (3) tick();
    d_in = 1'b0;
    for (int i = 0; i < 6 + SL; i++) begin
      tick();
      check_out("short_high", 1'b0, 1'b0, 1'b0, 8'd0);
    end

    // 3: accepted rise at edge N+3 (+SL), deassert at N+4
    d_in = 1'b1;
    for (int i = 0; i < 3 + SL; i++) begin
      tick();
      check_out("rise_wait", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    tick();
    check_out("rise_edge", 1'b1, 1'b1, 1'b0, 8'd1);
    tick();
    check_out("rise_done", 1'b1, 1'b0, 1'b0, 8'd1);

    // glitch low of two samples does not produce a fall
    d_in = 1'b0;
    repeat (2) tick();
    d_in = 1'b1;
    for (int i = 0; i < 4 + SL; i++) begin
      tick();
      check_out("low_glitch", 1'b1, 1'b0, 1'b0, 8'd1);
    end

    // accepted fall
    d_in = 1'b0;
    for (int i = 0; i < 3 + SL; i++) begin
      tick();
      check_out("fall_wait", 1'b1, 1'b0, 1'b0, 8'd1);
    end
    tick();
    check_out("fall_edge", 1'b0, 1'b0, 1'b1, 8'd1);
    tick();
    check_out("fall_done", 1'b0, 1'b0, 1'b0, 8'd1);

    // toggling input never settles: level holds, no pulses
    for (int i = 0; i < 16; i++) begin
      d_in = ~d_in;
      tick();
      check_out("toggle", 1'b0, 1'b0, 1'b0, 8'd1);
    end
    d_in = 1'b0;
    repeat (4 + SL) tick();

    // 4: count up to 255, then wrap to 0
    for (int i = 0; i < 254; i++) pulse_cycle();
    check_out("evt_255", 1'b0, 1'b0, 1'b0, 8'd255);
    pulse_cycle();
    check_out("evt_wrap", 1'b0, 1'b0, 1'b0, 8'd0);
    pulse_cycle();
    check_out("evt_after_wrap", 1'b0, 1'b0, 1'b0, 8'd1);
    pulse_cycle();
    check_out("evt_2", 1'b0, 1'b0, 1'b0, 8'd2);

    // clear coincident with an accepted rise gives 1
    d_in = 1'b1;
    repeat (3 + SL) tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check_out("clr_with_rise", 1'b1, 1'b1, 1'b0, 8'd1);
    tick();
    check_out("clr_with_rise_next", 1'b1, 1'b0, 1'b0, 8'd1);

    // clear alone gives 0
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check_out("clr_alone", 1'b1, 1'b0, 1'b0, 8'd0);
    tick();
    check_out("clr_alone_hold", 1'b1, 1'b0, 1'b0, 8'd0);

    // async reset while level is high clears immediately
    reset = 1'b1;
    #1;
    check_out("async_rst_high", 1'b0, 1'b0, 1'b0, 8'd0);
    d_in = 1'b0;
    tick();
    reset = 1'b0;
    pulse_cycle();
    check_out("pre_rst5", 1'b0, 1'b0, 1'b0, 8'd1);

    // 5: reset mid-check (CHECK_HIGH, stab_cnt=2)
    d_in = 1'b1;
    repeat (2 + SL) tick();
    check_out("mid_check", 1'b0, 1'b0, 1'b0, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    check_out("rst_mid_check", 1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3 + SL; i++) begin
      tick();
      check_out("fresh_wait", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    tick();
    check_out("fresh_rise", 1'b1, 1'b1, 1'b0, 8'd1);
    tick();
    check_out("fresh_rise_done", 1'b1, 1'b0, 1'b0, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
